// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: datapath width and the serial
// subtractor's FSM encoding.
package arith_pkg;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned WIDTH   = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_t;

endpackage

// File: rtl/nibble_serial_subtractor_cra.sv
// 4-bit ripple-carry adder slice from the arithmetic library.
module CRA (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[4];
    end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// 16-bit subtractor D = A - B - bin, one nibble per cycle through a single
// CRA slice, with valid/ready handshakes and borrow/overflow/zero flags.
module nibble_serial_subtractor
    import arith_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             bout,
    output logic             V,
    output logic             Z
);

    sub_state_t       state;
    sub_state_t       state_next;
    logic [1:0]       nib;
    logic             c;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       sum_nib;
    logic             carry_out;
    logic [3:0]       d_we;
    logic             accept;
    logic             last_nib;

    assign accept   = in_valid && (state == IDLE);
    assign last_nib = (nib == 2'd3);

    // Subtraction as A + ~B + ~bin, one nibble at a time.
    always_comb begin
        a_nib = a_reg[{nib, 2'b00} +: 4];
        b_nib = ~b_reg[{nib, 2'b00} +: 4];
    end

    CRA u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (c),
        .sum  (sum_nib),
        .cout (carry_out)
    );

    always_comb begin
        d_we = '0;
        if (state == RUN) begin
            d_we[nib] = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last_nib) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            nib   <= '0;
            c     <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            D     <= '0;
            bout  <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b0;
        end else if (accept) begin
            a_reg <= A;
            b_reg <= B;
            c     <= ~bin;
            nib   <= '0;
        end else if (state == RUN) begin
            c   <= carry_out;
            nib <= nib + 2'd1;
            for (int unsigned i = 0; i < NIBBLES; i++) begin
                if (d_we[i]) begin
                    D[i*4 +: 4] <= sum_nib;
                end
            end
            // Top nibble is still in flight, so flags use sum_nib directly.
            if (last_nib) begin
                bout <= ~carry_out;
                V    <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) & (sum_nib[3] ^ a_reg[WIDTH-1]);
                Z    <= ~|{sum_nib, D[11:0]};
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor: vector table, scoreboard
// queue, backpressure, input perturbation and mid-operation reset.
module tb_nibble_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] D;
    logic        bout;
    logic        V;
    logic        Z;

    always #5 clk = ~clk;

    nibble_serial_subtractor dut (
        .Clk       (clk),
        .Reset     (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .bout      (bout),
        .V         (V),
        .Z         (Z)
    );

    typedef struct {
        logic [15:0] d;
        logic        bout;
        logic        v;
        logic        z;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bi;
        exp_t        e;
    } vec_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bi);
        logic [16:0] diff;
        exp_t        e;
        diff   = {1'b0, a} - {1'b0, b} - {16'b0, bi};
        e.d    = diff[15:0];
        e.bout = diff[16];
        e.v    = (a[15] != b[15]) && (e.d[15] != a[15]);
        e.z    = (e.d == 16'h0000);
        return e;
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                         input exp_t e, input bit perturb, input int unsigned hold);
        int unsigned edges;
        exp_t        got;
        logic [19:0] snap;
        @(negedge clk);
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
        A = a; B = b; bin = bi; in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_busy", {31'b0, in_ready}, 32'd0);
        edges = 0;
        do begin
            if (perturb) begin
                A = 16'($urandom); B = 16'($urandom); bin = ~bin; in_valid = ~in_valid;
            end
            @(posedge clk);
            #1;
            edges++;
        end while (!out_valid && edges < 12);
        in_valid = 1'b0;
        check("latency", edges, 32'd4);
        check("out_valid_seen", {31'b0, out_valid}, 32'd1);
        check("in_ready_done", {31'b0, in_ready}, 32'd0);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check("D", {16'b0, D}, {16'b0, got.d});
            check("flags_bout_V_Z", {29'b0, bout, V, Z}, {29'b0, got.bout, got.v, got.z});
        end else begin
            check("scoreboard_nonempty", sb.size(), 32'd1);
        end
        snap = {D, bout, V, Z, in_ready};
        for (int unsigned i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_stable", {11'b0, snap, out_valid}, {11'b0, D, bout, V, Z, in_ready, 1'b1});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("handoff", {30'b0, out_valid, in_ready}, 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'h1234, 16'h0234, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0}};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1, 1'b0}};
        vecs[3] = '{16'h7FFF, 16'hFFFF, 1'b0, '{16'h8000, 1'b1, 1'b1, 1'b0}};
        vecs[4] = '{16'h0005, 16'h0005, 1'b0, '{16'h0000, 1'b0, 1'b0, 1'b1}};
        vecs[5] = '{16'h0005, 16'h0005, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0}};
        vecs[6] = '{16'hFFFF, 16'h0000, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b0}};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0}};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_state", {11'b0, D, bout, V, Z, out_valid, in_ready}, 32'h1);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].e, 1'b0, 0);
        end

        do_op(16'h1234, 16'h0234, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0}, 1'b1, 10);

        // Reset asserted during the second RUN cycle discards the operation.
        @(negedge clk);
        A = 16'hABCD; B = 16'h1111; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid_run", {12'b0, D, bout, V, Z, out_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            check("no_result_after_reset", {30'b0, out_valid, in_ready}, 32'd1);
        end
        do_op(16'h00FF, 16'h000F, 1'b0, '{16'h00F0, 1'b0, 1'b0, 1'b0}, 1'b0, 0);

        for (int k = 0; k < 16; k++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rbi;
            ra  = 16'($urandom);
            rb  = (k % 4 == 0) ? ra : 16'($urandom);
            rbi = 1'($urandom_range(0, 1));
            do_op(ra, rb, rbi, model(ra, rb, rbi), k[0], k[0] ? 2 : 0);
        end

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passed, checks);
        $fatal(1);
    end

endmodule
